// File: rtl/controllo_memoria.sv
// controllo_memoria: fills a RAM from an input byte stream, then drains it back in address order
module controllo_memoria #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr_write,
    output logic [ADDR_WIDTH-1:0] mem_addr_read,
    output logic [DATA_WIDTH-1:0] mem_dati,
    output logic [1:0]            mem_state,
    output logic                  mem_reset,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE = 2'b00, WRITE = 2'b01, READ = 2'b10, DONE = 2'b11} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   END_PTR = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] iss_ptr_q, iss_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  accept, wr_hs, stall, more, issue, last_hs;
    assign accept         = start && (state_q == IDLE || state_q == DONE);
    assign in_ready       = state_q == WRITE;
    assign wr_hs          = in_valid && in_ready;
    assign stall          = out_valid_q && !out_ready;
    assign more           = rd_ptr_q < END_PTR;
    assign issue          = state_q == READ && !stall && more;
    assign last_hs        = state_q == READ && out_valid_q && out_ready && iss_ptr_q == LAST;
    assign mem_we         = wr_hs;
    assign mem_dati       = in_data;
    assign mem_addr_write = wr_ptr_q;
    // once every address is issued, keep pointing at the last one so the RAM register holds the final byte
    assign mem_addr_read  = (stall || !more) ? iss_ptr_q : rd_ptr_q[ADDR_WIDTH-1:0];
    assign out_data       = mem_out;
    assign out_valid      = out_valid_q;
    assign mem_state      = state_q;
    assign mem_reset      = state_q == IDLE || (state_q == DONE && start);
    assign busy           = state_q == WRITE || state_q == READ;
    assign done           = state_q == DONE;
    // next state: start, write handshakes, read issue and final read handshake
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        iss_ptr_d   = iss_ptr_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            state_d     = WRITE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            iss_ptr_d   = '0;
            out_valid_d = 1'b0;
        end
        if (wr_hs) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
            state_d  = (wr_ptr_q == LAST) ? READ : state_q;
        end
        if (issue) begin
            iss_ptr_d   = rd_ptr_q[ADDR_WIDTH-1:0];
            rd_ptr_d    = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
            out_valid_d = 1'b1;
        end
        if (last_hs) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
        end
    end
    // state and pointer registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            iss_ptr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            iss_ptr_q   <= iss_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_controllo_memoria.sv
// tb_controllo_memoria: randomized scoreboard bench with a behavioural RAM and byte-order reference
module tb_controllo_memoria;
    localparam int DEPTH = 512;
    logic       clk = 1'b0;
    logic       reset, start, in_valid, out_ready;
    logic [7:0] in_data, out_data, mem_out, mem_dati;
    logic       in_ready, out_valid, mem_we, mem_reset, busy, done;
    logic [8:0] mem_addr_write, mem_addr_read;
    logic [1:0] mem_state;
    logic [7:0] ram [0:DEPTH-1];
    logic [7:0] exp_q [$];
    logic [7:0] exp_byte, prev_data;
    logic [1:0] prev_state = 2'b00;
    int         tests = 0, fails = 0, cyc = 0, wr_cnt = 0, read_age = -1, t0 = 0;
    bit         prev_stall = 0, saw_last_wr = 0;

    controllo_memoria dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_out(mem_out), .mem_we(mem_we), .mem_addr_write(mem_addr_write),
        .mem_addr_read(mem_addr_read), .mem_dati(mem_dati), .mem_state(mem_state),
        .mem_reset(mem_reset), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr_write] <= mem_dati;
        if (mem_state == 2'b10) mem_out <= ram[mem_addr_read];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp_v, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall  = 0;
            saw_last_wr = 0;
            read_age    = -1;
        end else begin
            if (saw_last_wr) check("read_after_last_write", 32'(mem_state), 2);
            saw_last_wr = 0;
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (mem_state == 2'b10) read_age = (prev_state == 2'b10) ? read_age + 1 : 0;
            else read_age = -1;
            if (read_age == 0) check("read_first_cycle_valid", 32'(out_valid), 0);
            if (read_age == 1) check("read_valid_latency", 32'(out_valid), 1);
            if (mem_we) begin
                check("wr_addr", 32'(mem_addr_write), 32'(wr_cnt));
                check("wr_in_range", 32'(wr_cnt < DEPTH), 1);
                if (mem_addr_write == 9'(DEPTH - 1)) saw_last_wr = 1;
                wr_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    exp_byte = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(exp_byte));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        prev_state = mem_state;
    end

    task automatic chk_reset_vals();
        check("rst_state", 32'(mem_state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_reset", 32'(mem_reset), 1);
        check("rst_wr_addr", 32'(mem_addr_write), 0);
        check("rst_rd_addr", 32'(mem_addr_read), 0);
    endtask

    task automatic chk_done();
        check("done_flag", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_state", 32'(mem_state), 3);
        check("done_out_valid", 32'(out_valid), 0);
        check("done_in_ready", 32'(in_ready), 0);
    endtask

    task automatic idle_quiet(input int n);
        in_valid  = 1;
        out_ready = 1;
        repeat (n) begin
            @(negedge clk);
            check("quiet_mem_we", 32'(mem_we), 0);
            check("quiet_out_valid", 32'(out_valid), 0);
            check("quiet_state", 32'(mem_state), 0);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic start_pass();
        if (done) check("done_mem_reset_low", 32'(mem_reset), 0);
        start = 1;
        t0    = cyc;
        exp_q.delete();
        wr_cnt = 0;
        #1 check("start_mem_reset", 32'(mem_reset), 1);
        @(posedge clk); #1;
        start = 0;
        check("start_state", 32'(mem_state), 1);
        check("start_busy", 32'(busy), 1);
        check("start_done_clr", 32'(done), 0);
        check("start_in_ready", 32'(in_ready), 1);
    endtask

    task automatic write_phase(input bit gapped, input bit rnd, input bit start_mid, input int n);
        int sent  = 0;
        int guard = 0;
        in_valid = 0;
        while (sent < n && guard < 4000) begin
            start    = start_mid && sent >= 100 && sent < 103;
            in_valid = gapped ? !in_valid : 1'b1;
            in_data  = rnd ? 8'($urandom) : 8'(sent);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            @(posedge clk); #1;
            guard++;
        end
        start    = 0;
        in_valid = 0;
        check("writes_accepted", 32'(sent), 32'(n));
    endtask

    task automatic read_phase(input int pct, input bit boundary);
        int guard = 0;
        while (!done && guard < 20000) begin
            if (boundary && exp_q.size() == 1 && out_valid) begin
                out_ready = 0;
                repeat (10) begin
                    @(negedge clk);
                    check("bnd_hold_data", 32'(out_data), 32'(exp_q[0]));
                    check("bnd_hold_state", 32'(mem_state), 2);
                    @(posedge clk); #1;
                end
                out_ready = 1;
                @(posedge clk); #1;
                check("bnd_done_state", 32'(mem_state), 3);
                check("bnd_done_flag", 32'(done), 1);
            end else begin
                out_ready = ($urandom_range(99) < pct);
                @(posedge clk); #1;
            end
            guard++;
        end
        check("read_completes", 32'(done), 1);
        check("all_bytes_out", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; start = 0; in_valid = 1; in_data = 8'h5a; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        #3 reset = 1;
        idle_quiet(5);
        // basic pass: sequential data, no backpressure, exact latency
        start_pass();
        write_phase(0, 0, 0, DEPTH);
        read_phase(100, 0);
        check("basic_cycles", 32'(cyc - t0), 1026);
        chk_done();
        repeat (3) @(posedge clk);
        #1 chk_done();
        // gapped input, random data, ignored start mid-write, 50% backpressure
        start_pass();
        write_phase(1, 1, 1, DEPTH);
        read_phase(50, 0);
        chk_done();
        // last-byte stall boundary
        start_pass();
        write_phase(0, 1, 0, DEPTH);
        read_phase(50, 1);
        chk_done();
        // reset in the middle of the write phase
        start_pass();
        write_phase(0, 1, 0, 200);
        in_valid = 1;
        reset    = 0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        reset = 1;
        idle_quiet(20);
        exp_q.delete();
        start_pass();
        write_phase(1, 1, 0, DEPTH);
        read_phase(70, 0);
        chk_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controllo_memoria.md
CONTROLLO_MEMORIA -- requirements
Module: controllo_memoria

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, byte width; DATA_DEPTH, default 512, number of RAM locations; ADDR_WIDTH, default 9, address width (2^ADDR_WIDTH = DATA_DEPTH).
REQ-002 Ports SHALL be as follows; the block has one clock, and reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- start  in  1  single-cycle request to begin a write-then-read pass.
- in_valid  in  1  input byte present.
- in_data  in  DATA_WIDTH  input byte.
- in_ready  out  1  controller accepts the input byte.
- out_valid  out  1  output byte present.
- out_data  out  DATA_WIDTH  output byte.
- out_ready  in  1  consumer accepts the output byte.
- mem_out  in  DATA_WIDTH  RAM registered read data (1-cycle latency when state=2'b10).
- mem_we  out  1  RAM write enable.
- mem_addr_write  out  ADDR_WIDTH  RAM write address.
- mem_addr_read  out  ADDR_WIDTH  RAM read address.
- mem_dati  out  DATA_WIDTH  RAM write data.
- mem_state  out  2  RAM phase code.
- mem_reset  out  1  synchronous, active-high clear of the RAM status flags.
- busy  out  1  pass in progress.
- done  out  1  pass complete (sticky).

Function
REQ-003 The FSM SHALL have four states with these encodings, driven on mem_state: IDLE=2'b00, WRITE=2'b01, READ=2'b10, DONE=2'b11.
REQ-004 In IDLE or DONE, start=1 SHALL cause a transition to WRITE on the next edge and clear wr_ptr, rd_ptr and done; start SHALL be ignored in WRITE and READ.
REQ-005 mem_reset SHALL equal 1 exactly when the state is IDLE, or on the cycle start is accepted in DONE.
REQ-006 In WRITE, in_ready SHALL be 1; in all other states, in_ready SHALL be 0.
REQ-007 mem_we SHALL equal in_valid AND in_ready (combinational); mem_dati SHALL equal in_data; mem_addr_write SHALL equal wr_ptr.
REQ-008 On each write handshake, wr_ptr SHALL increment by 1.
REQ-009 A handshake at wr_ptr=DATA_DEPTH-1 SHALL move the FSM to READ; wr_ptr SHALL wrap to 0 and SHALL NOT increment further.
REQ-010 In WRITE with in_valid=0, the FSM SHALL hold; there is no timeout.
REQ-011 In READ, the controller SHALL track rd_ptr (next address to issue) and iss_ptr (address whose data is on mem_out).
REQ-012 Stall is defined as out_valid=1 AND out_ready=0.
REQ-013 mem_addr_read SHALL equal iss_ptr when stalled and rd_ptr otherwise, so that mem_out holds stable during a stall.
REQ-014 out_data SHALL equal mem_out.
REQ-015 out_valid SHALL be registered: it SHALL go to 1 the cycle after the first address is issued in READ, and stay 1 until the final byte is accepted.
REQ-016 When not stalled in READ and rd_ptr < DATA_DEPTH, the controller SHALL issue rd_ptr: iss_ptr <= rd_ptr and rd_ptr <= rd_ptr+1; rd_ptr SHALL be ADDR_WIDTH+1 bits wide.
REQ-017 The handshake out_valid AND out_ready with iss_ptr=DATA_DEPTH-1 SHALL move the FSM to DONE and clear out_valid on the same edge.
REQ-018 Output bytes SHALL be emitted in address order 0..DATA_DEPTH-1, each exactly once, regardless of the out_ready pattern.
REQ-019 In DONE, done SHALL be 1 and busy SHALL be 0; busy SHALL be 1 in WRITE and READ.
REQ-020 In DONE, mem_state SHALL be 2'b11, so the RAM output register freezes on the last byte.
REQ-021 Write-to-read turnaround SHALL be 1 cycle: the first read address is issued on the first READ cycle.
REQ-022 With out_ready held at 1, throughput SHALL be 1 byte/cycle: the first out_valid appears 1 cycle after entering READ.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force: state IDLE; wr_ptr=0, rd_ptr=0, iss_ptr=0; out_valid=0, done=0, busy=0; in_ready=0, mem_we=0; mem_state=2'b00, mem_reset=1.
REQ-024 Reset asserted in WRITE or READ SHALL abort the pass; after release, no byte SHALL be emitted and no write SHALL occur until a new start.
REQ-025 Release of reset SHALL take effect at the first rising clk edge after reset goes to 1; there SHALL be no spurious handshake on that edge.

Verification
REQ-026 Basic pass: start, 512 bytes in_data=addr[7:0] with in_valid held 1, out_ready=1 -> 512 mem_we pulses at addresses 0..511; out_data sequence 0x00..0xFF twice; done=1; 1026 cycles from start to done.
REQ-027 Gapped input: in_valid toggling 1/0 -> exactly 512 writes, wr_ptr advances only on handshakes, READ is entered one cycle after the write at address 511.
REQ-028 Backpressure: random out_ready at 50% -> output byte order is identical to input, no byte is dropped or duplicated, and out_data is stable throughout every stall.
REQ-029 Boundary: out_ready=0 while iss_ptr=511 for 10 cycles -> out_data holds the byte at address 511, the FSM stays in READ, and DONE follows exactly one edge after out_ready rises.
REQ-030 Reset mid-pass: reset=0 for 2 cycles at write 200 -> all outputs at reset values immediately; no activity afterwards; a new start restarts at address 0.
REQ-031 Restart and ignored start: start in DONE -> mem_reset pulses, wr_ptr=0 and a new pass completes; start issued during WRITE -> no effect.
